code_match_seq: RTL
===================

// Module: code_match_seq
// PURPOSE
//   Sequential, parametrised code comparator for keypad entry. Accepts one digit per
//   digit_valid strobe and compares it against the matching digit of ref_code. After
//   DIGITS digits it reports match/mismatch, counts consecutive failures, and holds a
//   timed lockout after MAX_FAIL failures. Sits between keypad decoder and control FSM.
// PARAMETERS
//   DIGITS      4    digits per code (>=1)
//   DW          4    bits per digit (BCD = 4)
//   MAX_FAIL    3    consecutive mismatches that trigger lockout (>=1)
//   LOCK_CYCLES 16   lockout duration in clk cycles (>=1)
// PORTS
//   clk          in   1                   system clock, rising edge
//   rst_n        in   1                   asynchronous reset, active low
//   ref_code     in   DIGITS*DW           stored code; digit 0 = MS field [DIGITS*DW-1 -: DW]
//   digit_in     in   DW                  entered digit
//   digit_valid  in   1                   digit_in valid this cycle
//   clear        in   1                   abort current entry
//   busy         out  1                   entry in progress (COLLECT or EVAL)
//   done         out  1                   1-cycle pulse: code evaluated
//   match        out  1                   1-cycle pulse with done: all digits equal
//   mismatch     out  1                   1-cycle pulse with done: any digit differs
//   locked       out  1                   lockout active
//   digit_idx    out  $clog2(DIGITS+1)    digits accepted so far in current entry
//   fail_cnt     out  $clog2(MAX_FAIL+1)  consecutive mismatch count
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; busy, done, match, mismatch, locked = 0;
//     digit_idx = 0; fail_cnt = 0; internal eq flag = 1; lock counter = 0.
//   - States: IDLE, COLLECT, EVAL, LOCK. All outputs registered.
//   - IDLE: digit_valid -> accept digit 0, digit_idx=1; go COLLECT (or EVAL if DIGITS=1).
//   - Digit accept k: eq <= eq & (digit_in == ref_code digit k); ref_code sampled in the
//     accept cycle only (need not be stable between digits). eq reset to 1 on new entry.
//   - COLLECT: each digit_valid accepts next digit; on accepting digit DIGITS-1 go EVAL.
//     Cycles without digit_valid hold state (no timeout).
//   - EVAL (exactly 1 cycle; latency = 1 clk after last accept): done=1 and exactly one of
//     match/mismatch=1. match: fail_cnt<=0, go IDLE. mismatch: fail_cnt+1; if that equals
//     MAX_FAIL go LOCK, else IDLE. digit_idx<=0. digit_valid in EVAL is ignored (dropped).
//   - LOCK: locked=1 for exactly LOCK_CYCLES cycles; digit_valid and clear ignored; on exit
//     fail_cnt<=0, locked<=0, go IDLE.
//   - clear (IDLE/COLLECT): return IDLE, digit_idx<=0, eq<=1, fail_cnt unchanged, no done.
//     clear and digit_valid same cycle: clear wins, digit dropped.
//   - busy=1 in COLLECT and EVAL; 0 in IDLE and LOCK.
//   - fail_cnt saturates at MAX_FAIL (never wraps); digit_idx never exceeds DIGITS.
//   - rst_n low mid-entry or mid-lock: immediate return to reset values.
// TESTING
//   1 ref=16'h1234; digits 1,2,3,4 on consecutive cycles -> done+match 1 clk after digit 4;
//     fail_cnt=0, busy falls with IDLE.
//   2 ref=16'h1234; digits 1,2,9,4 -> done+mismatch; fail_cnt=1; next entry 1234 -> match,
//     fail_cnt=0.
//   3 Three wrong entries (MAX_FAIL=3) -> locked=1 for exactly 16 cycles, digit_valid pulses
//     during lock produce no done; after lock fail_cnt=0, entry 1234 -> match.
//   4 Enter 1,2 then clear (with simultaneous digit_valid) -> digit_idx=0, no done;
//     then 1234 -> match (eq flag restarted).
//   5 Digits with idle gaps of 0..5 cycles, digit_valid during EVAL -> ignored; rst_n pulse
//     after digit 3 -> all outputs at reset values, following 1234 -> match.
//   6 DIGITS=1, DW=4, ref=4'h7: digit 7 -> match next clk; digit 3 -> mismatch.

Source files
------------

// File: rtl/code_match_seq.sv
// Sequential keypad code comparator with consecutive-failure lockout.
// Digits arrive one per digit_valid strobe. Each digit is checked against its
// field of ref_code at the moment it is accepted. After the last digit, a single
// EVAL cycle reports the result. MAX_FAIL consecutive mismatches start a timed
// lockout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the first digit of an entry
// COLLECT | digits 1..DIGITS-1 being accepted
// EVAL    | one cycle: done plus match/mismatch, fail counter update
// LOCK    | lockout countdown; all input strobes ignored
module code_match_seq #(
  parameter int DIGITS      = 4,
  parameter int DW          = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DIGITS*DW-1:0]           ref_code,
  input  logic [DW-1:0]                  digit_in,
  input  logic                           digit_valid,
  input  logic                           clear,
  output logic                           busy,
  output logic                           done,
  output logic                           match,
  output logic                           mismatch,
  output logic                           locked,
  output logic [$clog2(DIGITS+1)-1:0]    digit_idx,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

  localparam int IW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    LOCK    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          eq, eq_nxt;
  logic [IW-1:0] idx_nxt;
  logic [FW-1:0] fail_nxt, fail_inc;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic [DW-1:0] ref_digit;
  logic          busy_nxt, done_nxt, match_nxt, mismatch_nxt, locked_nxt;

  // Select the reference digit addressed by the current entry position (digit 0 is the MS field).
  always_comb begin
    ref_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        ref_digit = ref_code[(DIGITS-1-k)*DW +: DW];
      end
    end
  end

  // State register: FSM state, entry datapath and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      eq        <= 1'b1;
      digit_idx <= '0;
      fail_cnt  <= '0;
      lock_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      mismatch  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      eq        <= eq_nxt;
      digit_idx <= idx_nxt;
      fail_cnt  <= fail_nxt;
      lock_cnt  <= lock_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      match     <= match_nxt;
      mismatch  <= mismatch_nxt;
      locked    <= locked_nxt;
    end
  end

  // Next-state and datapath update; eq is always 1 on entering IDLE so no separate restart is needed.
  always_comb begin
    state_nxt = state;
    eq_nxt    = eq;
    idx_nxt   = digit_idx;
    fail_nxt  = fail_cnt;
    lock_nxt  = lock_cnt;
    fail_inc  = fail_cnt + 1'b1;
    case (state)
      IDLE, COLLECT: begin
        if (clear) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          eq_nxt    = 1'b1;
        end else if (digit_valid) begin
          eq_nxt    = eq & (digit_in == ref_digit);
          idx_nxt   = digit_idx + 1'b1;
          state_nxt = (digit_idx == IW'(DIGITS - 1)) ? EVAL : COLLECT;
        end
      end
      EVAL: begin
        idx_nxt   = '0;
        eq_nxt    = 1'b1;
        state_nxt = IDLE;
        if (eq) begin
          fail_nxt = '0;
        end else if (fail_cnt < FW'(MAX_FAIL)) begin
          fail_nxt = fail_inc;
          if (fail_inc == FW'(MAX_FAIL)) begin
            state_nxt = LOCK;
            lock_nxt  = LW'(LOCK_CYCLES - 1);
          end
        end
      end
      LOCK: begin
        if (lock_cnt == '0) begin
          state_nxt = IDLE;
          fail_nxt  = '0;
        end else begin
          lock_nxt = lock_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    busy_nxt     = (state_nxt == COLLECT) || (state_nxt == EVAL);
    done_nxt     = (state_nxt == EVAL);
    match_nxt    = done_nxt & eq_nxt;
    mismatch_nxt = done_nxt & ~eq_nxt;
    locked_nxt   = (state_nxt == LOCK);
  end

endmodule
